// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule expander.
// Loads one 512-bit block as 16 big-endian words (W0 first) and then emits the
// 64-word schedule W0..W63, one word per output handshake. A 16-word sliding
// window holds W[t..t+15]. Each accepted output shifts the window and appends
// W[t+16].
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_word holds a valid message word
//   in_ready   block accepts a word this cycle (LOAD state)
//   in_word    32-bit message word
//   out_valid  out_word/out_idx hold a valid schedule word (EMIT state)
//   out_ready  downstream accepts the word this cycle
//   out_word   schedule word W_t
//   out_idx    t, 0..63
//   out_last   high with out_valid when t == 63
module sha256_msg_schedule (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [5:0]  out_idx,
    output logic        out_last
);

    typedef enum logic {StLoad, StEmit} state_e;

    state_e      state_q;
    logic [31:0] w_q [16];
    logic [4:0]  lc_q;
    logic [5:0]  t_q;
    logic [31:0] next_word;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Window holds W[t..t+15], so this is W[t+16]; wraps mod 2^32.
    assign next_word = sigma1(w_q[14]) + w_q[9] + sigma0(w_q[1]) + w_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StLoad;
            lc_q    <= 5'd0;
            t_q     <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= 32'd0;
            end
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (in_valid) begin
                        w_q[lc_q[3:0]] <= in_word;
                        // Last load word: go straight to EMIT with counters cleared.
                        if (lc_q == 5'd15) begin
                            state_q <= StEmit;
                            lc_q    <= 5'd0;
                            t_q     <= 6'd0;
                        end else begin
                            lc_q <= lc_q + 5'd1;
                        end
                    end
                end
                StEmit: begin
                    if (out_ready) begin
                        for (int i = 0; i < 15; i++) begin
                            w_q[i] <= w_q[i + 1];
                        end
                        w_q[15] <= next_word;
                        if (t_q == 6'd63) begin
                            state_q <= StLoad;
                            t_q     <= 6'd0;
                        end else begin
                            t_q <= t_q + 6'd1;
                        end
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

    // All outputs decode registered state only; out_ready never reaches them.
    assign in_ready  = (state_q == StLoad);
    assign out_valid = (state_q == StEmit);
    assign out_word  = out_valid ? w_q[0] : 32'd0;
    assign out_idx   = t_q;
    assign out_last  = out_valid && (t_q == 6'd63);

endmodule

// File: tb/tb_sha256_msg_schedule.sv
module tb_sha256_msg_schedule;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [5:0]  out_idx;
    logic        out_last;

    sha256_msg_schedule dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] cur_blk [16];
    logic [31:0] exp_w   [64];
    logic [31:0] obs_w   [64];
    int          first_hs;
    int          last_hs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference model: textbook array form of the schedule recurrence.
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic set_block(input bit abc);
        for (int i = 0; i < 16; i++) cur_blk[i] = 32'd0;
        if (abc) begin
            cur_blk[0]  = 32'h61626380;
            cur_blk[15] = 32'h00000018;
        end
        for (int t = 0; t < 64; t++) begin
            if (t < 16) exp_w[t] = cur_blk[t];
            else exp_w[t] = ref_s1(exp_w[t-2]) + exp_w[t-7] + ref_s0(exp_w[t-15]) + exp_w[t-16];
        end
    endtask

    // Called at a negedge. Gappy inserts two idle cycles before each odd word.
    task automatic load_block(input bit gappy, input bit hold);
        for (int i = 0; i < 16; i++) begin
            if (gappy && (i % 2 == 1)) begin
                repeat (2) begin
                    in_valid = 1'b0;
                    in_word  = 32'hDEADBEEF;
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_word  = cur_blk[i];
            if (i == 0 || i == 15) check($sformatf("in_ready_load%0d", i), {31'd0, in_ready}, 32'd1);
            @(negedge clk);
        end
        in_valid = hold;
        in_word  = 32'hBADC0FFE;
        check("out_valid_after_load", {31'd0, out_valid}, 32'd1);
    endtask

    // Called at a negedge right after loading. stall_at / abort_at < 0 disables.
    task automatic drain(input int stall_at, input int abort_at);
        for (int k = 0; k < 64; k++) begin
            obs_w[k] = out_word;
            check($sformatf("idx%0d", k), {26'd0, out_idx}, k[31:0]);
            check($sformatf("word%0d", k), out_word, exp_w[k]);
            check($sformatf("last%0d", k), {31'd0, out_last}, (k == 63) ? 32'd1 : 32'd0);
            if (k == 0 || k == 63) begin
                check($sformatf("valid%0d", k), {31'd0, out_valid}, 32'd1);
                check($sformatf("in_ready_emit%0d", k), {31'd0, in_ready}, 32'd0);
            end
            if (k == stall_at) begin
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_idx", {26'd0, out_idx}, k[31:0]);
                    check("stall_word", out_word, exp_w[k]);
                    check("stall_valid", {31'd0, out_valid}, 32'd1);
                end
                out_ready = 1'b1;
            end
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_out_valid", {31'd0, out_valid}, 32'd0);
                check("abort_in_ready", {31'd0, in_ready}, 32'd1);
                check("abort_out_idx", {26'd0, out_idx}, 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (k == 63) in_valid = 1'b0;
            @(negedge clk);
            if (k == 0) first_hs = cyc;
            if (k == 63) last_hs = cyc;
        end
        check("in_ready_after_last", {31'd0, in_ready}, 32'd1);
        check("out_valid_after_last", {31'd0, out_valid}, 32'd0);
    endtask

    int c0;
    int l1;

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_word   = 32'd0;
        out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_word", out_word, 32'd0);
        check("rst_out_idx", {26'd0, out_idx}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // "abc" block, full throughput
        set_block(1'b1);
        load_block(1'b0, 1'b0);
        drain(-1, -1);
        check("abc_w16", obs_w[16], 32'h61626380);
        check("abc_w17", obs_w[17], 32'h000F0000);

        // All-zero block
        set_block(1'b0);
        load_block(1'b0, 1'b0);
        drain(-1, -1);

        // Backpressure at idx 20
        set_block(1'b1);
        load_block(1'b0, 1'b0);
        drain(20, -1);

        // Gappy input, in_valid held high through EMIT
        load_block(1'b1, 1'b1);
        drain(-1, -1);

        // Reset at idx 40, then a fresh block
        load_block(1'b0, 1'b0);
        drain(-1, 40);
        load_block(1'b0, 1'b0);
        drain(-1, -1);

        // Back-to-back blocks
        c0 = cyc;
        load_block(1'b0, 1'b0);
        drain(-1, -1);
        l1 = last_hs;
        load_block(1'b0, 1'b0);
        drain(-1, -1);
        check("b2b_w0_gap", first_hs - l1, 32'd17);
        check("b2b_total", last_hs - c0, 32'd160);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
